// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and the bitwise round functions.
package sha256_pkg;

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h (index 0..7) to their successors.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] v_in  [8],
    input  logic [31:0] k,
    input  logic [31:0] w,
    output logic [31:0] v_out [8]
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1 = v_in[7] + bsig1(v_in[4]) + ch(v_in[4], v_in[5], v_in[6]) + k + w;
    assign t2 = bsig0(v_in[0]) + maj(v_in[0], v_in[1], v_in[2]);

    assign v_out[0] = t1 + t2;

    // Every other word shifts down one slot; e additionally absorbs T1.
    for (genvar gi = 1; gi < 8; gi++) begin : g_shift
        if (gi == 4) begin : g_e
            assign v_out[gi] = v_in[gi-1] + t1;
        end else begin : g_pass
            assign v_out[gi] = v_in[gi-1];
        end
    end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: one round per w_rdy cycle, then H += a..h and publish the digest.
module sha256_compress
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         init,
    input  logic         w_rdy,
    input  logic [31:0]  W,
    output logic [4:0]   count,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

    state_t       state_reg;
    state_t       state_next;
    logic [6:0]   t_reg;
    logic [31:0]  h_reg  [8];
    logic [31:0]  v_reg  [8];
    logic [31:0]  v_next [8];
    logic [31:0]  h_sum  [8];
    logic [255:0] h_sum_flat;
    logic [255:0] digest_reg;
    logic         busy_reg;
    logic         done_reg;

    sha256_round u_round (
        .v_in  (v_reg),
        .k     (K_TABLE[t_reg[5:0]]),
        .w     (W),
        .v_out (v_next)
    );

    // H0 lands in the most significant word of the digest.
    for (genvar gi = 0; gi < 8; gi++) begin : g_hsum
        assign h_sum[gi] = h_reg[gi] + v_reg[gi];
        assign h_sum_flat[255-32*gi -: 32] = h_sum[gi];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = ROUND;
            ROUND:   if (w_rdy && t_reg == LAST_T) state_next = FINAL;
            FINAL:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            t_reg      <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            digest_reg <= '0;
            h_reg      <= IV;
            for (int i = 0; i < 8; i++) v_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (init) h_reg <= IV;
                    end
                end
                LOAD: begin
                    v_reg <= h_reg;
                    t_reg <= '0;
                end
                ROUND: begin
                    // A low w_rdy freezes the round, so W is ignored that cycle.
                    if (w_rdy) begin
                        v_reg <= v_next;
                        t_reg <= t_reg + 7'd1;
                    end
                end
                FINAL: begin
                    h_reg      <= h_sum;
                    digest_reg <= h_sum_flat;
                    done_reg   <= 1'b1;
                    busy_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign count  = t_reg[4:0];
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign digest = digest_reg;

endmodule

// File: tb/tb_sha256_compress.sv
// Bench for sha256_compress: known-answer table, stall/abort/re-start sequences, random chained blocks vs a reference model.
module tb_sha256_compress;

    localparam int ROUNDS = 64;

    typedef logic [0:7][31:0]  hash_t;
    typedef logic [0:15][31:0] block_t;
    typedef logic [0:63][31:0] sched_t;

    typedef struct packed {
        logic [511:0] text;
        logic [6:0]   len;
        hash_t        expected;
    } vec_t;

    localparam logic [31:0] KB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hash_t IV_B = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         init;
    logic         w_rdy;
    logic [31:0]  W;
    logic [4:0]   count;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    int tests = 0;
    int fails = 0;

    sha256_compress #(.ROUNDS(ROUNDS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .init   (init),
        .w_rdy  (w_rdy),
        .W      (W),
        .count  (count),
        .busy   (busy),
        .done   (done),
        .digest (digest)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sched_t schedule(input block_t b);
        sched_t s;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) s[t] = b[t];
            else s[t] = (rotr(s[t-2], 17) ^ rotr(s[t-2], 19) ^ (s[t-2] >> 10)) + s[t-7]
                      + (rotr(s[t-15], 7) ^ rotr(s[t-15], 18) ^ (s[t-15] >> 3)) + s[t-16];
        end
        return s;
    endfunction

    // Textbook compression of one block, working variables held as v[0]=a .. v[7]=h.
    function automatic hash_t compress(input hash_t hin, input block_t b);
        sched_t      s;
        logic [31:0] v [8];
        logic [31:0] t1;
        logic [31:0] t2;
        hash_t       hout;
        s = schedule(b);
        for (int i = 0; i < 8; i++) v[i] = hin[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KB[t] + s[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[i] = hin[i] + v[i];
        return hout;
    endfunction

    // Message padding for texts up to 119 bytes (one or two blocks).
    function automatic void pad(input logic [511:0] text, input int len,
                                output block_t b0, output block_t b1, output int n);
        logic [7:0] bytes [128];
        longint     bits;
        for (int i = 0; i < 128; i++) bytes[i] = 8'h00;
        for (int i = 0; i < len; i++) bytes[i] = text[8*(len-1-i) +: 8];
        bytes[len] = 8'h80;
        n = (len + 9 <= 64) ? 1 : 2;
        bits = longint'(len) * 8;
        for (int k = 0; k < 8; k++) bytes[64*n-1-k] = 8'(bits >> (8*k));
        for (int w = 0; w < 16; w++) begin
            b0[w] = {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]};
            b1[w] = {bytes[64+4*w], bytes[64+4*w+1], bytes[64+4*w+2], bytes[64+4*w+3]};
        end
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Runs one block; called and returning at a negedge. stall_pct = % of ROUND cycles with w_rdy low.
    // pulse_round >= 0 raises start while busy at that round; rst_round >= 0 aborts there.
    task automatic run_block(input block_t blk, input logic ini, input int stall_pct,
                             input int pulse_round, input int rst_round,
                             output int lat, output int stalls, output logic got_done);
        sched_t s;
        int     r;
        int     guard;
        logic   wr;
        logic   early;
        s = schedule(blk);
        lat = 0; stalls = 0; got_done = 1'b0; early = 1'b0;
        start = 1'b1; init = ini; w_rdy = 1'b0;
        @(posedge clk); lat++;
        @(negedge clk);
        start = 1'b0; init = 1'($urandom); w_rdy = 1'b1; W = $urandom;
        @(posedge clk); lat++;
        r = 0; guard = 0;
        while (r < ROUNDS && guard < 1000) begin
            @(negedge clk);
            if (r == rst_round) begin
                rst = 1'b1; w_rdy = 1'b1; W = $urandom;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0; w_rdy = 1'b0;
                check("busy_after_rst", 256'(busy), 256'(0));
                check("done_after_rst", 256'(done), 256'(0));
                check("digest_after_rst", digest, 256'(0));
                check("count_after_rst", 256'(count), 256'(0));
                repeat (80) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (done) early = 1'b1;
                end
                check("no_done_after_rst", 256'(early), 256'(0));
                return;
            end
            check($sformatf("count_r%0d", r), 256'(count), 256'(r[4:0]));
            if (done) early = 1'b1;
            start = (r == pulse_round);
            init = 1'b1;
            wr = ($urandom_range(99) >= 32'(stall_pct));
            w_rdy = wr;
            W = wr ? s[r] : $urandom;
            @(posedge clk); lat++; guard++;
            if (wr) r++;
            else stalls++;
        end
        @(negedge clk);
        start = 1'b0; w_rdy = 1'($urandom); W = $urandom;
        check("no_early_done", 256'(early), 256'(0));
        check("busy_in_final", 256'(busy), 256'(1));
        guard = 0;
        while (!done && guard < 10) begin
            @(posedge clk); lat++;
            @(negedge clk);
            guard++;
        end
        got_done = done;
        w_rdy = 1'b0;
        $display("[TB] block init=%0d stalls=%0d latency=%0d done=%0d digest=%h", ini, stalls, lat, got_done, digest);
    endtask

    vec_t   vecs [3];
    block_t b0, b1, abc_blk, blk;
    int     n, lat, st;
    logic   gd, ini;
    hash_t  h_model, abc_exp;

    initial begin
        vecs[0].text = {488'h0, "abc"};
        vecs[0].len = 7'd3;
        vecs[0].expected = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
        vecs[1].text = '0;
        vecs[1].len = 7'd0;
        vecs[1].expected = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
        vecs[2].text = {64'h0, "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"};
        vecs[2].len = 7'd56;
        vecs[2].expected = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

        rst = 1'b1; start = 1'b0; init = 1'b0; w_rdy = 1'b0; W = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 256'(busy), 256'(0));
        check("reset_done", 256'(done), 256'(0));
        check("reset_digest", digest, 256'(0));
        check("reset_count", 256'(count), 256'(0));
        rst = 1'b0;

        // Known-answer messages with w_rdy held high; later blocks start in the done cycle.
        for (int v = 0; v < 3; v++) begin
            pad(vecs[v].text, int'(vecs[v].len), b0, b1, n);
            for (int bi = 0; bi < n; bi++) begin
                run_block((bi == 0) ? b0 : b1, (bi == 0), 0, -1, -1, lat, st, gd);
                check($sformatf("done_v%0d_b%0d", v, bi), 256'(gd), 256'(1));
                check($sformatf("latency_v%0d_b%0d", v, bi), 256'(lat), 256'(67));
            end
            check($sformatf("digest_v%0d", v), digest, vecs[v].expected);
            check($sformatf("busy_after_done_v%0d", v), 256'(busy), 256'(0));
        end

        pad(vecs[0].text, 3, abc_blk, b1, n);
        abc_exp = vecs[0].expected;

        run_block(abc_blk, 1'b1, 30, -1, -1, lat, st, gd);
        check("stall_done", 256'(gd), 256'(1));
        check("stall_digest", digest, abc_exp);
        check("stall_latency", 256'(lat), 256'(67 + st));

        run_block(abc_blk, 1'b1, 0, 20, -1, lat, st, gd);
        check("pulse_done", 256'(gd), 256'(1));
        check("pulse_digest", digest, abc_exp);
        check("pulse_latency", 256'(lat), 256'(67));

        run_block(abc_blk, 1'b1, 0, -1, 30, lat, st, gd);
        run_block(abc_blk, 1'b1, 0, -1, -1, lat, st, gd);
        check("post_rst_done", 256'(gd), 256'(1));
        check("post_rst_digest", digest, abc_exp);

        // Random blocks, chained or re-initialised, against the reference model.
        h_model = compress(IV_B, abc_blk);
        for (int i = 0; i < 6; i++) begin
            for (int w = 0; w < 16; w++) blk[w] = $urandom;
            ini = (i == 3) ? 1'b1 : 1'b0;
            if (i != 3 && $urandom_range(3) == 0) ini = 1'b1;
            if (ini) h_model = IV_B;
            h_model = compress(h_model, blk);
            run_block(blk, ini, 20, -1, -1, lat, st, gd);
            check($sformatf("rand%0d_done", i), 256'(gd), 256'(1));
            check($sformatf("rand%0d_digest", i), digest, h_model);
            check($sformatf("rand%0d_latency", i), 256'(lat), 256'(67 + st));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sha256_compress.md
# sha256_compress

SHA-256 compression engine, directly downstream of `expansion`. It consumes the 64-word schedule W[t] one word per round, iterates the working variables a..h, and adds them into the chaining hash H to produce a 256-bit digest per 512-bit block. It also drives the round index that `expansion` uses to sequence its schedule RAM.

## Interface
Parameters:
- `ROUNDS`, 64: compression rounds per block. Fixed by SHA-256; the parameter exists for bench shortening only.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `start` input 1: begin compressing one block. Sampled in IDLE only.
- `init` input 1: sampled with `start`.
  - 1: load H from the IV (first block of a message).
  - 0: chain from the current H.
- `w_rdy` input 1: W is valid this cycle. Driven by `expansion`.
- `W` input 32: schedule word for the current round.
- `count` output 5: low 5 bits of the round counter, wired to `expansion`.
- `busy` output 1: high from accepted `start` until `done`.
- `done` output 1: one-cycle pulse when `digest` updates.
- `digest` output 256: H0..H7, H0 in [255:224]. Held until the next block completes.

## Operation
- Reset values:
  - state IDLE, round counter 0, `count` 0.
  - `busy` 0, `done` 0, `digest` 0.
  - H = IV, a..h = 0.
- IDLE:
  - `start`=1 captures `init`, sets `busy`, and goes to LOAD.
  - If `init`=1, H is loaded with the IV on the same edge.
- LOAD: a..h ← H0..H7, t ← 0, go to ROUND.
- ROUND:
  - On an edge with `w_rdy`=1, perform one round using K[t] and W:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W
    - T2 = Σ0(a) + Maj(a,b,c)
    - shift: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
    - t ← t+1
  - `w_rdy`=0 stalls: a..h and t are held, and W is ignored.
  - After round t=ROUNDS-1 is performed, go to FINAL.
- FINAL:
  - Hi ← Hi + working variable i, for all eight words.
  - `digest` ← new H, `done` ← 1, `busy` ← 0, go to IDLE.
- Arithmetic:
  - All additions are 32-bit modulo 2^32, with no carry out.
  - Σ0 = ROTR2^ROTR13^ROTR22.
  - Σ1 = ROTR6^ROTR11^ROTR25.
- Boundary cases:
  - `start` while `busy` is ignored.
  - `start` in the same cycle that `done` is high is accepted, since the state is IDLE.
  - `rst` mid-block aborts the block and returns every output to its reset value; no `done` is issued.
  - `w_rdy` is don't-care outside ROUND.

## Timing
- `start` sampled at edge E0 → LOAD at E0.
- E1: a..h loaded, ROUND entered.
- Rounds are performed at E2..E65 when `w_rdy` is held high.
- E66: FINAL; `digest` and `done` are valid in the cycle after E66.
- Start-to-done latency is 67 cycles plus the number of stall cycles.
- `count` = t[4:0] is registered and changes on the edge after each performed round. It wraps 31→0 at t=32.
- The W supplied in a cycle must correspond to the current `count`/t. Combinational depth T1→a is one cycle.

## Structure
- `sha256_pkg` holds:
  - K[0..63] constant array.
  - IV H0..H7 constants.
  - State enum: IDLE, LOAD, ROUND, FINAL.
  - Functions `ch`, `maj`, `bsig0`, `bsig1`.
- Sub-module `sha256_round`: combinational, inputs a..h, K, W; outputs the next a..h. It is instantiated once.
- The top module holds the FSM, the round counter, H, a..h, and the digest register.

## Test plan
- Bench drives W from a reference schedule model. Case: "abc", single block, `init`=1, `w_rdy` held high.
  - Required: `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - Required: `done` 67 cycles after `start`.
- Case: empty message.
  - Required: `digest` = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Case: two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq". First block `init`=1, second block `init`=0.
  - Required: final `digest` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Case: "abc" with `w_rdy` randomly low 30% of ROUND cycles.
  - Required: same digest as the first case.
  - Required: `done` delayed by exactly the number of stall cycles.
- Case: `start` pulsed again while `busy`.
  - Required: the pulse is ignored, and the digest is unchanged vs the first case.
- Case: `rst` at round 30.
  - Required: next cycle `busy`=0, `digest`=0, `count`=0, and no `done`.
  - Required: a following "abc" with `init`=1 yields the first-case digest.
